pd_hash_sequencer: RTL and testbench
====================================

// Module: pd_hash_sequencer
// PURPOSE
//  Sequences the SHA-256 compression core through one Bitcoin header hash.
//  Passes: chunk1 (first 512 header bits), chunk2 (last 128 bits plus padding), then the
//  digest pass of the double SHA-256. Drives hash_select to the Packet Decoder chunk mux
//  and init-vector select to the core. Owns the start/done handshake and a done-timeout watchdog.
// PARAMETERS
//  TIMEOUT  255  max cycles in a *_WAIT state without hash_done before error (>=1)
// PORTS
//  clk            in   1  system clock
//  n_rst          in   1  asynchronous active-low reset
//  new_block      in   1  1-cycle pulse: new header loaded, full hash required
//  nonce_next     in   1  1-cycle pulse: same header, nonce changed
//  hash_done      in   1  1-cycle pulse from core: current compression finished
//  hash_select    out  2  0=chunk1, 1=chunk2, 2=digest pass (value 3 never driven)
//  iv_sel         out  2  0=SHA-256 IV, 1=chain previous digest, 2=cached midstate
//  hash_start     out  1  1-cycle start pulse to core
//  hash_abort     out  1  1-cycle pulse: core must discard in-flight compression
//  load_midstate  out  1  1-cycle pulse: core digest after chunk1 is to be captured as midstate
//  result_valid   out  1  1-cycle pulse: final double-hash digest valid at core output
//  busy           out  1  high in every state except IDLE, DONE, ERR
//  error          out  1  sticky timeout flag
// BEHAVIOUR
//  - All outputs registered or Moore-decoded from state. Reset: state=IDLE, all outputs 0,
//    hash_select=0, iv_sel=0, timer=0, midstate_valid=0.
//  - States: IDLE, C1_START, C1_WAIT, C2_START, C2_WAIT, D_START, D_WAIT, DONE, ERR.
//  - *_START lasts exactly 1 cycle with hash_start=1, then goes to its *_WAIT state.
//  - Per-pass selects, held from *_START through *_WAIT:
//      C1: hash_select=0, iv_sel=0
//      C2: hash_select=1, iv_sel=1 (iv_sel=2 when entered via midstate path)
//      D:  hash_select=2, iv_sel=0
//  - IDLE transitions: new_block -> C1_START. nonce_next -> see CONFIGURATION.
//  - Wait transitions:
//      C1_WAIT + hash_done -> C2_START; load_midstate=1 in that same C2_START cycle.
//      C2_WAIT + hash_done -> D_START.
//      D_WAIT  + hash_done -> DONE.
//  - DONE lasts 1 cycle with result_valid=1, then returns to IDLE.
//  - Latency: new_block at cycle 0 gives hash_start at cycle 1. A done->start gap is 1 cycle.
//  - hash_done outside any *_WAIT state is ignored.
//  - Timer clears on entry to each *_WAIT and increments each WAIT cycle without hash_done.
//    When it reaches TIMEOUT: go to ERR, set error=1, pulse hash_abort.
//  - ERR holds until new_block, which clears error and goes to C1_START. nonce_next is ignored in ERR.
//  - new_block in any busy state: hash_abort=1 for 1 cycle, then next state C1_START.
//    Also clears midstate_valid. No result_valid is produced for the aborted hash.
//  - nonce_next while busy: ignored, not queued.
//  - new_block and nonce_next in the same cycle: new_block wins.
//  - n_rst asserted mid-hash: immediate return to reset values; no abort pulse.
// CONFIGURATION
//  MIDSTATE_CACHE_EN defined:
//    - midstate_valid is set by load_midstate.
//    - IDLE + nonce_next with midstate_valid -> C2_START with iv_sel=2, skipping chunk1.
//    - nonce_next without midstate_valid behaves as new_block.
//  MIDSTATE_CACHE_EN undefined:
//    - no midstate_valid register; nonce_next behaves exactly as new_block.
//    - iv_sel never equals 2; load_midstate is tied to 0.
// STRUCTURE
//  pd_pkg:
//    - typedef enum logic [3:0] pd_seq_state_t
//    - localparams HS_CHUNK1=2'd0, HS_CHUNK2=2'd1, HS_DIGEST=2'd2
//    - localparams IV_STD=2'd0, IV_CHAIN=2'd1, IV_MID=2'd2
//  Sub-module pd_wait_timer:
//    - width $clog2(TIMEOUT+1); inputs clear, enable; output expired.
//  Sequencer FSM in this file.
// TESTING
//  1. new_block@0, core done 64 cyc after each start -> starts @1/66/131; result_valid
//     1 cycle after the third done; hash_select 0,1,2.
//  2. hash_done withheld, TIMEOUT=8 -> error=1 and hash_abort pulse after 8 WAIT cycles;
//     new_block clears error and restarts at C1_START.
//  3. new_block during C2_WAIT -> hash_abort 1 cycle, then hash_start with hash_select=0;
//     no result_valid from the aborted run.
//  4. MIDSTATE_CACHE_EN, full hash then nonce_next -> first start has hash_select=1, iv_sel=2;
//     exactly 2 starts before result_valid.
//  5. nonce_next+new_block same cycle in IDLE -> chunk1 path. nonce_next while busy -> no effect.
//  6. n_rst low during D_WAIT -> all outputs 0 asynchronously; stray hash_done in IDLE ignored.

Source files
------------

// File: rtl/pd_pkg.sv
// Shared types and constants for the Bitcoin header hash sequencer.
// Holds the sequencer state encoding, the chunk-mux and IV select codes,
// and a small state-classification helper.
package pd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_C1_START = 4'd1,
    ST_C1_WAIT  = 4'd2,
    ST_C2_START = 4'd3,
    ST_C2_WAIT  = 4'd4,
    ST_D_START  = 4'd5,
    ST_D_WAIT   = 4'd6,
    ST_DONE     = 4'd7,
    ST_ERR      = 4'd8,
    ST_ABORT    = 4'd9
  } pd_seq_state_t;

  // Packet Decoder chunk mux selects
  localparam logic [1:0] HS_CHUNK1 = 2'd0;
  localparam logic [1:0] HS_CHUNK2 = 2'd1;
  localparam logic [1:0] HS_DIGEST = 2'd2;

  // Compression core init-vector selects
  localparam logic [1:0] IV_STD   = 2'd0;
  localparam logic [1:0] IV_CHAIN = 2'd1;
  localparam logic [1:0] IV_MID   = 2'd2;

  // True for the states in which the core is computing and the watchdog runs
  function automatic logic is_wait_state(input pd_seq_state_t st);
    case (st)
      ST_C1_WAIT, ST_C2_WAIT, ST_D_WAIT: is_wait_state = 1'b1;
      default:                           is_wait_state = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pd_wait_timer.sv
// Done-timeout watchdog counter for the hash sequencer.
// Counts cycles spent waiting for the core; expired is asserted in the
// TIMEOUT-th consecutive enabled cycle so the sequencer can leave on that edge.
module pd_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);
  localparam logic [W-1:0] ONE   = W'(1);
  localparam logic [W-1:0] ZERO  = W'(0);

  logic [W-1:0] count_r;

  // Wait-cycle counter: cleared outside the wait states, saturates at the limit
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_r <= ZERO;
    end else if (clear) begin
      count_r <= ZERO;
    end else if (enable && (count_r != LIMIT)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && (count_r == LIMIT);

endmodule

// File: rtl/pd_hash_sequencer.sv
// Bitcoin header double-SHA-256 pass sequencer.
// Steps the compression core through chunk1, chunk2 and the digest pass,
// drives the chunk mux / IV selects, owns the start/done handshake, and
// aborts to an error state when the core fails to report done in time.
// Optional build macro MIDSTATE_CACHE_EN: caches the chunk1 midstate so that
// a nonce-only change restarts from chunk2 with the cached midstate IV.
module pd_hash_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       new_block,
  input  logic       nonce_next,
  input  logic       hash_done,
  output logic [1:0] hash_select,
  output logic [1:0] iv_sel,
  output logic       hash_start,
  output logic       hash_abort,
  output logic       load_midstate,
  output logic       result_valid,
  output logic       busy,
  output logic       error
);

  import pd_pkg::*;

  pd_seq_state_t state_r;
  logic [1:0]    hash_select_r;
  logic [1:0]    iv_sel_r;
  logic          hash_start_r;
  logic          hash_abort_r;
  logic          result_valid_r;
  logic          busy_r;
  logic          error_r;

  logic          wait_s;
  logic          timer_clear_s;
  logic          timer_en_s;
  logic          timer_expired_s;

`ifdef MIDSTATE_CACHE_EN
  logic          load_midstate_r;
  logic          midstate_valid_r;
`endif

  assign wait_s        = is_wait_state(state_r);
  assign timer_clear_s = !wait_s;
  assign timer_en_s    = wait_s && !hash_done;

  pd_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (timer_clear_s),
    .enable  (timer_en_s),
    .expired (timer_expired_s)
  );

  // Sequencer FSM: state transitions together with all registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r          <= ST_IDLE;
      hash_select_r    <= HS_CHUNK1;
      iv_sel_r         <= IV_STD;
      hash_start_r     <= 1'b0;
      hash_abort_r     <= 1'b0;
      result_valid_r   <= 1'b0;
      busy_r           <= 1'b0;
      error_r          <= 1'b0;
`ifdef MIDSTATE_CACHE_EN
      load_midstate_r  <= 1'b0;
      midstate_valid_r <= 1'b0;
`endif
    end else begin
      // single-cycle strobes default low
      hash_start_r    <= 1'b0;
      hash_abort_r    <= 1'b0;
      result_valid_r  <= 1'b0;
`ifdef MIDSTATE_CACHE_EN
      load_midstate_r <= 1'b0;
`endif
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (new_block || (nonce_next && (state_r == ST_IDLE))) begin
`ifdef MIDSTATE_CACHE_EN
            if (!new_block && midstate_valid_r) begin
              // nonce-only change: resume from the cached midstate
              state_r       <= ST_C2_START;
              hash_start_r  <= 1'b1;
              hash_select_r <= HS_CHUNK2;
              iv_sel_r      <= IV_MID;
              busy_r        <= 1'b1;
            end else begin
              state_r          <= ST_C1_START;
              hash_start_r     <= 1'b1;
              hash_select_r    <= HS_CHUNK1;
              iv_sel_r         <= IV_STD;
              busy_r           <= 1'b1;
              midstate_valid_r <= 1'b0;
            end
`else
            state_r       <= ST_C1_START;
            hash_start_r  <= 1'b1;
            hash_select_r <= HS_CHUNK1;
            iv_sel_r      <= IV_STD;
            busy_r        <= 1'b1;
`endif
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end

        ST_C1_START, ST_C2_START, ST_D_START: begin
          if (new_block) begin
            state_r      <= ST_ABORT;
            hash_abort_r <= 1'b1;
            busy_r       <= 1'b1;
`ifdef MIDSTATE_CACHE_EN
            midstate_valid_r <= 1'b0;
`endif
          end else if (state_r == ST_C1_START) begin
            state_r <= ST_C1_WAIT;
          end else if (state_r == ST_C2_START) begin
            state_r <= ST_C2_WAIT;
          end else begin
            state_r <= ST_D_WAIT;
          end
        end

        ST_C1_WAIT: begin
          if (new_block) begin
            state_r      <= ST_ABORT;
            hash_abort_r <= 1'b1;
            busy_r       <= 1'b1;
`ifdef MIDSTATE_CACHE_EN
            midstate_valid_r <= 1'b0;
`endif
          end else if (hash_done) begin
            state_r       <= ST_C2_START;
            hash_start_r  <= 1'b1;
            hash_select_r <= HS_CHUNK2;
            iv_sel_r      <= IV_CHAIN;
`ifdef MIDSTATE_CACHE_EN
            load_midstate_r  <= 1'b1;
            midstate_valid_r <= 1'b1;
`endif
          end else if (timer_expired_s) begin
            state_r      <= ST_ERR;
            error_r      <= 1'b1;
            hash_abort_r <= 1'b1;
            busy_r       <= 1'b0;
          end else begin
            state_r <= ST_C1_WAIT;
          end
        end

        ST_C2_WAIT: begin
          if (new_block) begin
            state_r      <= ST_ABORT;
            hash_abort_r <= 1'b1;
            busy_r       <= 1'b1;
`ifdef MIDSTATE_CACHE_EN
            midstate_valid_r <= 1'b0;
`endif
          end else if (hash_done) begin
            state_r       <= ST_D_START;
            hash_start_r  <= 1'b1;
            hash_select_r <= HS_DIGEST;
            iv_sel_r      <= IV_STD;
          end else if (timer_expired_s) begin
            state_r      <= ST_ERR;
            error_r      <= 1'b1;
            hash_abort_r <= 1'b1;
            busy_r       <= 1'b0;
          end else begin
            state_r <= ST_C2_WAIT;
          end
        end

        ST_D_WAIT: begin
          if (new_block) begin
            state_r      <= ST_ABORT;
            hash_abort_r <= 1'b1;
            busy_r       <= 1'b1;
`ifdef MIDSTATE_CACHE_EN
            midstate_valid_r <= 1'b0;
`endif
          end else if (hash_done) begin
            state_r        <= ST_DONE;
            result_valid_r <= 1'b1;
            busy_r         <= 1'b0;
          end else if (timer_expired_s) begin
            state_r      <= ST_ERR;
            error_r      <= 1'b1;
            hash_abort_r <= 1'b1;
            busy_r       <= 1'b0;
          end else begin
            state_r <= ST_D_WAIT;
          end
        end

        ST_ABORT: begin
          // abort pulse has been issued; restart the full hash
          state_r       <= ST_C1_START;
          hash_start_r  <= 1'b1;
          hash_select_r <= HS_CHUNK1;
          iv_sel_r      <= IV_STD;
          busy_r        <= 1'b1;
        end

        ST_ERR: begin
          if (new_block) begin
            state_r       <= ST_C1_START;
            hash_start_r  <= 1'b1;
            hash_select_r <= HS_CHUNK1;
            iv_sel_r      <= IV_STD;
            busy_r        <= 1'b1;
            error_r       <= 1'b0;
`ifdef MIDSTATE_CACHE_EN
            midstate_valid_r <= 1'b0;
`endif
          end else begin
            state_r <= ST_ERR;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign hash_select  = hash_select_r;
  assign iv_sel       = iv_sel_r;
  assign hash_start   = hash_start_r;
  assign hash_abort   = hash_abort_r;
  assign result_valid = result_valid_r;
  assign busy         = busy_r;
  assign error        = error_r;
`ifdef MIDSTATE_CACHE_EN
  assign load_midstate = load_midstate_r;
`else
  assign load_midstate = 1'b0;
`endif

endmodule

// File: tb/tb_pd_hash_sequencer.sv
// Directed bench for pd_hash_sequencer: full hash timing, watchdog timeout,
// abort on new header, midstate / nonce handling, and asynchronous reset.
module tb_pd_hash_sequencer;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic new_block = 1'b0;
  logic nonce_next = 1'b0;
  logic hash_done = 1'b0;

  logic [1:0] hash_select, iv_sel;
  logic hash_start, hash_abort, load_midstate, result_valid, busy, error;
  logic [1:0] hash_select_t, iv_sel_t;
  logic hash_start_t, hash_abort_t, load_midstate_t, result_valid_t, busy_t, error_t;
  logic [9:0] outs, outs_t;

  assign outs   = {hash_select, iv_sel, hash_start, hash_abort, load_midstate, result_valid, busy, error};
  assign outs_t = {hash_select_t, iv_sel_t, hash_start_t, hash_abort_t, load_midstate_t,
                   result_valid_t, busy_t, error_t};

  pd_hash_sequencer #(.TIMEOUT(255)) dut (
    .clk(clk), .n_rst(n_rst), .new_block(new_block), .nonce_next(nonce_next),
    .hash_done(hash_done), .hash_select(hash_select), .iv_sel(iv_sel),
    .hash_start(hash_start), .hash_abort(hash_abort), .load_midstate(load_midstate),
    .result_valid(result_valid), .busy(busy), .error(error)
  );

  pd_hash_sequencer #(.TIMEOUT(8)) dut_t (
    .clk(clk), .n_rst(n_rst), .new_block(new_block), .nonce_next(nonce_next),
    .hash_done(hash_done), .hash_select(hash_select_t), .iv_sel(iv_sel_t),
    .hash_start(hash_start_t), .hash_abort(hash_abort_t), .load_midstate(load_midstate_t),
    .result_valid(result_valid_t), .busy(busy_t), .error(error_t)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc[$];
  int start_hs[$];
  int start_iv[$];
  int rv_cyc[$];
  int lm_cyc[$];
  int abort_cnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_log();
    start_cyc.delete(); start_hs.delete(); start_iv.delete();
    rv_cyc.delete(); lm_cyc.delete();
    abort_cnt = 0;
  endtask

  task automatic apply_reset();
    new_block = 1'b0; nonce_next = 1'b0; hash_done = 1'b0;
    n_rst = 1'b0;
    step(); step();
    n_rst = 1'b1;
    step();
  endtask

  // Core model: answers every start with hash_done lat cycles later; stops at result_valid
  task automatic run_core(input int lat, input int limit, input int init_pend);
    int pend;
    pend = init_pend;
    for (int i = 0; i < limit; i++) begin
      hash_done = 1'b0;
      if (pend == 0) begin
        hash_done = 1'b1;
        pend = -1;
      end
      if (hash_start === 1'b1) begin
        start_cyc.push_back(cyc);
        start_hs.push_back(int'(hash_select));
        start_iv.push_back(int'(iv_sel));
        pend = lat;
      end
      if (pend > 0) pend--;
      if (load_midstate === 1'b1) lm_cyc.push_back(cyc);
      if (hash_abort === 1'b1) abort_cnt++;
      if (result_valid === 1'b1) begin
        rv_cyc.push_back(cyc);
        break;
      end
      step();
    end
    hash_done = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    step();
    total++;
    if (outs !== 10'd0) begin bad++; $display("FAIL reset_outs: got %b want %b", outs, 10'd0); end
    total++;
    if (outs_t !== 10'd0) begin bad++; $display("FAIL reset_outs_t: got %b want %b", outs_t, 10'd0); end
    n_rst = 1'b1;
    step();
  endtask

  task automatic test_full_hash();
    int e_c[3];
    int e_hs[3];
    int e_iv[3];
    e_c = '{1, 66, 131}; e_hs = '{0, 1, 2}; e_iv = '{0, 1, 0};
    apply_reset();
    clear_log();
    cyc = 0;
    new_block = 1'b1;
    step();
    new_block = 1'b0;
    run_core(64, 400, -1);
    total++;
    if (start_cyc.size() != 3) begin
      bad++; $display("FAIL full_start_count: got %0d want 3", start_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (start_cyc[i] != e_c[i] || start_hs[i] != e_hs[i] || start_iv[i] != e_iv[i]) begin
          bad++;
          $display("FAIL full_start%0d: got cyc=%0d hs=%0d iv=%0d want cyc=%0d hs=%0d iv=%0d",
                   i, start_cyc[i], start_hs[i], start_iv[i], e_c[i], e_hs[i], e_iv[i]);
        end
      end
    end
    total++;
    if (rv_cyc.size() != 1 || rv_cyc[0] != 196) begin
      bad++; $display("FAIL full_result_valid: got n=%0d cyc=%0d want n=1 cyc=196", rv_cyc.size(), rv_cyc[0]);
    end
`ifdef MIDSTATE_CACHE_EN
    total++;
    if (lm_cyc.size() != 1 || lm_cyc[0] != 66) begin
      bad++; $display("FAIL full_load_midstate: got n=%0d cyc=%0d want n=1 cyc=66", lm_cyc.size(), lm_cyc[0]);
    end
`else
    total++;
    if (lm_cyc.size() != 0) begin
      bad++; $display("FAIL full_load_midstate: got n=%0d want 0", lm_cyc.size());
    end
`endif
    total++;
    if (abort_cnt != 0) begin bad++; $display("FAIL full_abort: got %0d want 0", abort_cnt); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL done_busy: got %b want 0", busy); end
    step();
    total++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_after_done: got rv=%b busy=%b want 0 0", result_valid, busy);
    end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    apply_reset();
    cyc = 0;
    new_block = 1'b1;
    step();
    new_block = 1'b0;
    total++;
    if (hash_start_t !== 1'b1 || hash_select_t !== 2'd0) begin
      bad++; $display("FAIL to_start: got start=%b hs=%0d want 1 0", hash_start_t, hash_select_t);
    end
    repeat (8) begin
      step();
      if (error_t === 1'b1 || hash_abort_t === 1'b1) early++;
    end
    total++;
    if (early != 0) begin bad++; $display("FAIL to_early: got %0d want 0", early); end
    step();
    total++;
    if (error_t !== 1'b1 || hash_abort_t !== 1'b1 || busy_t !== 1'b0) begin
      bad++; $display("FAIL to_err: got err=%b abort=%b busy=%b want 1 1 0", error_t, hash_abort_t, busy_t);
    end
    nonce_next = 1'b1;
    step();
    nonce_next = 1'b0;
    total++;
    if (hash_abort_t !== 1'b0 || error_t !== 1'b1 || hash_start_t !== 1'b0) begin
      bad++; $display("FAIL to_hold: got abort=%b err=%b start=%b want 0 1 0", hash_abort_t, error_t, hash_start_t);
    end
    new_block = 1'b1;
    step();
    new_block = 1'b0;
    total++;
    if (error_t !== 1'b0 || hash_start_t !== 1'b1 || hash_select_t !== 2'd0) begin
      bad++; $display("FAIL to_restart: got err=%b start=%b hs=%0d want 0 1 0", error_t, hash_start_t, hash_select_t);
    end
  endtask

  task automatic test_abort();
    apply_reset();
    clear_log();
    cyc = 0;
    new_block = 1'b1;
    step();
    new_block = 1'b0;
    repeat (64) step();
    hash_done = 1'b1;
    step();
    hash_done = 1'b0;
    total++;
    if (hash_start !== 1'b1 || hash_select !== 2'd1) begin
      bad++; $display("FAIL ab_c2_start: got start=%b hs=%0d want 1 1", hash_start, hash_select);
    end
    repeat (4) step();
    new_block = 1'b1;
    step();
    new_block = 1'b0;
    total++;
    if (hash_abort !== 1'b1 || hash_start !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL ab_pulse: got abort=%b start=%b busy=%b want 1 0 1", hash_abort, hash_start, busy);
    end
    step();
    total++;
    if (hash_abort !== 1'b0 || hash_start !== 1'b1 || hash_select !== 2'd0 || iv_sel !== 2'd0) begin
      bad++; $display("FAIL ab_restart: got abort=%b start=%b hs=%0d iv=%0d want 0 1 0 0",
                      hash_abort, hash_start, hash_select, iv_sel);
    end
    run_core(64, 400, -1);
    total++;
    if (start_cyc.size() != 3 || start_cyc[0] != 72 || start_cyc[2] != 202) begin
      bad++; $display("FAIL ab_rerun_starts: got n=%0d first=%0d want n=3 first=72", start_cyc.size(), start_cyc[0]);
    end
    total++;
    if (rv_cyc.size() != 1 || rv_cyc[0] != 267) begin
      bad++; $display("FAIL ab_result_valid: got n=%0d cyc=%0d want n=1 cyc=267", rv_cyc.size(), rv_cyc[0]);
    end
    step();
  endtask

  task automatic test_nonce();
    int e_n;
    int e_c[3];
    int e_hs[3];
    int e_iv[3];
    int e_rv;
`ifdef MIDSTATE_CACHE_EN
    e_n = 2; e_c = '{1, 66, 0}; e_hs = '{1, 2, 0}; e_iv = '{2, 0, 0}; e_rv = 131;
`else
    e_n = 3; e_c = '{1, 66, 131}; e_hs = '{0, 1, 2}; e_iv = '{0, 1, 0}; e_rv = 196;
`endif
    clear_log();
    cyc = 0;
    nonce_next = 1'b1;
    step();
    nonce_next = 1'b0;
    run_core(64, 400, -1);
    total++;
    if (start_cyc.size() != e_n) begin
      bad++; $display("FAIL nonce_start_count: got %0d want %0d", start_cyc.size(), e_n);
    end else begin
      for (int i = 0; i < e_n; i++) begin
        total++;
        if (start_cyc[i] != e_c[i] || start_hs[i] != e_hs[i] || start_iv[i] != e_iv[i]) begin
          bad++;
          $display("FAIL nonce_start%0d: got cyc=%0d hs=%0d iv=%0d want cyc=%0d hs=%0d iv=%0d",
                   i, start_cyc[i], start_hs[i], start_iv[i], e_c[i], e_hs[i], e_iv[i]);
        end
      end
    end
    total++;
    if (rv_cyc.size() != 1 || rv_cyc[0] != e_rv) begin
      bad++; $display("FAIL nonce_result_valid: got n=%0d cyc=%0d want n=1 cyc=%0d", rv_cyc.size(), rv_cyc[0], e_rv);
    end
    step();
  endtask

  task automatic test_priority_and_busy_nonce();
    clear_log();
    cyc = 0;
    new_block = 1'b1;
    nonce_next = 1'b1;
    step();
    new_block = 1'b0;
    nonce_next = 1'b0;
    total++;
    if (hash_start !== 1'b1 || hash_select !== 2'd0 || iv_sel !== 2'd0) begin
      bad++; $display("FAIL both_pulses: got start=%b hs=%0d iv=%0d want 1 0 0", hash_start, hash_select, iv_sel);
    end
    nonce_next = 1'b1;
    step();
    nonce_next = 1'b0;
    run_core(64, 400, 63);
    total++;
    if (start_cyc.size() != 2 || start_cyc[0] != 66 || start_hs[0] != 1 || start_iv[0] != 1) begin
      bad++; $display("FAIL busy_nonce_starts: got n=%0d cyc=%0d hs=%0d iv=%0d want n=2 cyc=66 hs=1 iv=1",
                      start_cyc.size(), start_cyc[0], start_hs[0], start_iv[0]);
    end
    total++;
    if (rv_cyc.size() != 1 || rv_cyc[0] != 196) begin
      bad++; $display("FAIL busy_nonce_rv: got n=%0d cyc=%0d want n=1 cyc=196", rv_cyc.size(), rv_cyc[0]);
    end
    step();
  endtask

  task automatic test_async_reset();
    int stray;
    stray = 0;
    apply_reset();
    clear_log();
    cyc = 0;
    new_block = 1'b1;
    step();
    new_block = 1'b0;
    run_core(64, 140, -1);
    total++;
    if (busy !== 1'b1 || hash_select !== 2'd2) begin
      bad++; $display("FAIL ar_in_dwait: got busy=%b hs=%0d want 1 2", busy, hash_select);
    end
    n_rst = 1'b0;
    #1;
    total++;
    if (outs !== 10'd0) begin bad++; $display("FAIL ar_outs: got %b want %b", outs, 10'd0); end
    step();
    n_rst = 1'b1;
    hash_done = 1'b1;
    step();
    hash_done = 1'b0;
    repeat (3) begin
      if (hash_start !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0 || hash_abort !== 1'b0) stray++;
      step();
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL ar_stray_done: got %0d want 0", stray); end
  endtask

  initial begin
    test_reset();
    test_full_hash();
    test_timeout();
    test_abort();
    test_full_hash();
    test_nonce();
    test_priority_and_busy_nonce();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
